bus_arbiter: RTL and testbench

Arbitrates the shared 6502 RAM bus (19-bit address, 8-bit data, rw) between the 6502 and two DMA masters: master 0 is the boot loader, master 1 is a later peripheral DMA. It owns the 6502 `busen` (BE) and `clock_stop` lines. Before handing the bus to a DMA master it parks the CPU: it stops the clock at a bus-cycle boundary, then floats the CPU bus. Until the first master 0 tenure completes, the CPU never runs.

---
 rtl/bifrost_bus_pkg.sv | 22 ++
 rtl/bus_arbiter_rr_pick.sv | 23 ++
 rtl/bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bifrost_bus_pkg.sv
// Shared types for the 6502 RAM bus arbiter.
//   ADDR_W / DATA_W : RAM bus widths
//   arb_state_t     : arbiter FSM states
//   master_t        : DMA master index (0 = boot loader, 1 = peripheral DMA)
package bifrost_bus_pkg;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 8;

    typedef logic master_t;

    typedef enum logic [2:0] {
        BOOT,
        CPU_RUN,
        STOPPING,
        PARK,
        GRANTED,
        RELEASE,
        RESTART
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// 2-way round-robin chooser.
//   req         in  per-master request
//   last_served in  master served most recently
//   winner      out chosen master (don't-care when no request)
module rr_pick
    import bifrost_bus_pkg::*;
(
    input  logic [1:0] req,
    input  master_t    last_served,
    output master_t    winner
);

    // A lone requester wins; on a tie the master not served last wins.
    always_comb begin
        winner = ~last_served;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            default: winner = ~last_served;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates the 6502 RAM bus between the CPU and two DMA masters. The CPU is
// parked (clock stopped at a bus-cycle boundary, then BE dropped) before any
// DMA grant, and is not started until the first boot-loader tenure completes.
//   clock, reset        : system clock, synchronous active-high reset
//   cpu_cycle_end       : end-of-6502-bus-cycle pulse
//   req / grant         : per-master request (level) / grant (one-hot or zero)
//   dma_address0/1, dma_data0/1, dma_rw0/1 : master bus inputs
//   address, data, rw   : muxed RAM bus (combinational from registered grant)
//   bus_drive           : a DMA master owns the bus
//   busen, clock_stop   : 6502 BE and clock-run control (0 = disabled/stopped)
module bus_arbiter
    import bifrost_bus_pkg::*;
#(
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned MIN_CPU = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_cycle_end,
    input  logic [1:0]        req,
    output logic [1:0]        grant,
    input  logic [ADDR_W-1:0] dma_address0,
    input  logic [ADDR_W-1:0] dma_address1,
    input  logic [DATA_W-1:0] dma_data0,
    input  logic [DATA_W-1:0] dma_data1,
    input  logic              dma_rw0,
    input  logic              dma_rw1,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              rw,
    output logic              bus_drive,
    output logic              busen,
    output logic              clock_stop
);

    localparam int unsigned SETTLE_W = $clog2(SETTLE + 1);
    localparam int unsigned RUN_W    = $clog2(MIN_CPU + 1);

    arb_state_t          state, state_nxt;
    logic [SETTLE_W-1:0] settle_cnt, settle_cnt_nxt;
    logic [RUN_W-1:0]    run_cnt, run_cnt_nxt;
    master_t             target, target_nxt;
    master_t             last_served, last_served_nxt;
    master_t             winner;
    logic                boot_done, boot_done_nxt;
    logic [1:0]          grant_nxt;
    logic                bus_drive_nxt, busen_nxt, clock_stop_nxt;

    rr_pick u_rr_pick (
        .req         (req),
        .last_served (last_served),
        .winner      (winner)
    );

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= BOOT;
            settle_cnt  <= '0;
            run_cnt     <= '0;
            target      <= 1'b0;
            last_served <= 1'b1;
            boot_done   <= 1'b0;
            grant       <= 2'b00;
            bus_drive   <= 1'b0;
            busen       <= 1'b0;
            clock_stop  <= 1'b0;
        end else begin
            state       <= state_nxt;
            settle_cnt  <= settle_cnt_nxt;
            run_cnt     <= run_cnt_nxt;
            target      <= target_nxt;
            last_served <= last_served_nxt;
            boot_done   <= boot_done_nxt;
            grant       <= grant_nxt;
            bus_drive   <= bus_drive_nxt;
            busen       <= busen_nxt;
            clock_stop  <= clock_stop_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt       = state;
        settle_cnt_nxt  = settle_cnt;
        run_cnt_nxt     = run_cnt;
        target_nxt      = target;
        last_served_nxt = last_served;
        boot_done_nxt   = boot_done;
        grant_nxt       = grant;
        bus_drive_nxt   = bus_drive;
        busen_nxt       = busen;
        clock_stop_nxt  = clock_stop;

        case (state)
            // CPU already stopped and floated; only the boot loader is served.
            BOOT: begin
                if (req[0]) begin
                    target_nxt     = 1'b0;
                    settle_cnt_nxt = '0;
                    state_nxt      = PARK;
                end
            end
            // Run counter saturates; requests wait for a minimum CPU run.
            CPU_RUN: begin
                if (run_cnt == RUN_W'(MIN_CPU)) begin
                    if (|req) begin
                        target_nxt = winner;
                        state_nxt  = STOPPING;
                    end
                end else begin
                    run_cnt_nxt = run_cnt + RUN_W'(1);
                end
            end
            STOPPING: begin
                if (cpu_cycle_end) begin
                    clock_stop_nxt = 1'b0;
                    settle_cnt_nxt = '0;
                    state_nxt      = PARK;
                end
            end
            // First PARK edge drops BE; grant follows after SETTLE more edges.
            PARK: begin
                busen_nxt = 1'b0;
                if (settle_cnt == SETTLE_W'(SETTLE)) begin
                    grant_nxt     = target ? 2'b10 : 2'b01;
                    bus_drive_nxt = 1'b1;
                    state_nxt     = GRANTED;
                end else begin
                    settle_cnt_nxt = settle_cnt + SETTLE_W'(1);
                end
            end
            // The other master's request simply waits; no pre-emption.
            GRANTED: begin
                if (!req[target]) begin
                    grant_nxt       = 2'b00;
                    bus_drive_nxt   = 1'b0;
                    last_served_nxt = target;
                    if (target == 1'b0) begin
                        boot_done_nxt = 1'b1;
                    end
                    settle_cnt_nxt  = '0;
                    state_nxt       = RELEASE;
                end
            end
            RELEASE: begin
                if (settle_cnt == SETTLE_W'(SETTLE - 1)) begin
                    busen_nxt = 1'b1;
                    state_nxt = RESTART;
                end else begin
                    settle_cnt_nxt = settle_cnt + SETTLE_W'(1);
                end
            end
            // The CPU clock only ever restarts once the boot loader has run.
            RESTART: begin
                clock_stop_nxt = boot_done;
                run_cnt_nxt    = '0;
                state_nxt      = CPU_RUN;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // Bus mux driven from the registered grant; idle bus reads with zeros.
    always_comb begin
        address = '0;
        data    = '0;
        rw      = 1'b1;
        if (grant[0]) begin
            address = dma_address0;
            data    = dma_data0;
            rw      = dma_rw0;
        end else if (grant[1]) begin
            address = dma_address1;
            data    = dma_data1;
            rw      = dma_rw1;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (SETTLE=2, MIN_CPU=16).
module tb_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_cycle_end = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  grant;
    logic [18:0] dma_address0 = 19'h0E000;
    logic [18:0] dma_address1 = 19'h12345;
    logic [7:0]  dma_data0 = 8'h5A;
    logic [7:0]  dma_data1 = 8'hA5;
    logic        dma_rw0 = 1'b0;
    logic        dma_rw1 = 1'b1;
    logic [18:0] address;
    logic [7:0]  data;
    logic        rw, bus_drive, busen, clock_stop;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.SETTLE(2), .MIN_CPU(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_cycle_end (cpu_cycle_end),
        .req           (req),
        .grant         (grant),
        .dma_address0  (dma_address0),
        .dma_address1  (dma_address1),
        .dma_data0     (dma_data0),
        .dma_data1     (dma_data1),
        .dma_rw0       (dma_rw0),
        .dma_rw1       (dma_rw1),
        .address       (address),
        .data          (data),
        .rw            (rw),
        .bus_drive     (bus_drive),
        .busen         (busen),
        .clock_stop    (clock_stop)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Called right after a release edge; CPU cycle ends are offered every cycle,
    // so the grant lands a fixed number of edges later.
    task automatic wait_grant(input string tag, input logic [1:0] exp, input int exp_steps);
        int n = 0;
        cpu_cycle_end = 1'b1;
        while (grant == 2'b00 && n < 100) begin
            step();
            n++;
        end
        cpu_cycle_end = 1'b0;
        check({tag, "_grant"}, 32'(grant), 32'(exp));
        check({tag, "_latency"}, 32'(n), 32'(exp_steps));
    endtask

    // Safety invariants, sampled between edges.
    always @(negedge clock) begin
        if (!reset) begin
            check("inv_onehot", 32'($countones(grant) <= 1), 32'd1);
            check("inv_busen_grant", 32'(busen & (|grant)), 32'd0);
            check("inv_clkstop_busen", 32'(clock_stop & ~busen), 32'd0);
        end
    end

    initial begin
        // Reset values
        req = 2'b11;
        step(); step(); step();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busen", 32'(busen), 32'd0);
        check("rst_clock_stop", 32'(clock_stop), 32'd0);
        check("rst_bus_drive", 32'(bus_drive), 32'd0);
        check("rst_rw", 32'(rw), 32'd1);
        check("rst_address", 32'(address), 32'd0);
        check("rst_data", 32'(data), 32'd0);

        // Boot: grant[0] SETTLE+1 edges after req[0] is seen; req[1] ignored
        reset = 1'b0;
        step();
        check("boot_b0_grant", 32'(grant), 32'd0);
        step();
        step();
        check("boot_b2_grant", 32'(grant), 32'd0);
        check("boot_b2_busen", 32'(busen), 32'd0);
        step();
        check("boot_b3_grant", 32'(grant), 32'h1);
        check("boot_bus_drive", 32'(bus_drive), 32'd1);
        check("boot_clock_stop", 32'(clock_stop), 32'd0);
        check("boot_address", 32'(address), 32'h0E000);
        check("boot_data", 32'(data), 32'h5A);
        check("boot_rw", 32'(rw), 32'd0);
        step();
        check("boot_hold_grant", 32'(grant), 32'h1);

        // Boot release: BE back after SETTLE, clock one edge later
        req = 2'b10;
        step();
        check("rel_grant", 32'(grant), 32'd0);
        check("rel_bus_drive", 32'(bus_drive), 32'd0);
        check("rel_rw", 32'(rw), 32'd1);
        check("rel_address", 32'(address), 32'd0);
        step();
        check("rel_r1_busen", 32'(busen), 32'd0);
        step();
        check("rel_r2_busen", 32'(busen), 32'd1);
        check("rel_r2_clock_stop", 32'(clock_stop), 32'd0);
        step();
        check("rel_r3_clock_stop", 32'(clock_stop), 32'd1);

        // req[1] pending, no cycle end: clock keeps running, no grant
        for (int i = 0; i < 30; i++) begin
            step();
            check("withheld_grant", 32'(grant), 32'd0);
            check("withheld_clock_stop", 32'(clock_stop), 32'd1);
        end
        cpu_cycle_end = 1'b1;
        step();
        cpu_cycle_end = 1'b0;
        check("stop_k_clock_stop", 32'(clock_stop), 32'd0);
        check("stop_k_busen", 32'(busen), 32'd1);
        step();
        check("stop_k1_busen", 32'(busen), 32'd0);
        check("stop_k1_grant", 32'(grant), 32'd0);
        step();
        check("stop_k2_grant", 32'(grant), 32'd0);
        step();
        check("stop_k3_grant", 32'(grant), 32'h2);
        check("m1_bus_drive", 32'(bus_drive), 32'd1);
        check("m1_address", 32'(address), 32'h12345);
        check("m1_data", 32'(data), 32'hA5);
        check("m1_rw", 32'(rw), 32'd1);

        // Master 0 queued behind master 1, no pre-emption
        req = 2'b11;
        step(); step(); step();
        check("no_preempt_grant", 32'(grant), 32'h2);
        req = 2'b01;
        step();
        check("m1_rel_grant", 32'(grant), 32'd0);
        wait_grant("m0_after_m1", 2'b01, 24);

        // After a master 0 tenure, a tie goes to master 1
        req = 2'b11;
        step();
        check("m0_hold_grant", 32'(grant), 32'h1);
        req = 2'b10;
        step();
        check("m0_rel_grant", 32'(grant), 32'd0);
        req = 2'b11;
        wait_grant("rr_m1_first", 2'b10, 24);
        req = 2'b01;
        step();
        check("m1b_rel_grant", 32'(grant), 32'd0);
        wait_grant("m0_after_run", 2'b01, 24);

        // Reset during GRANTED drops everything on the same edge
        reset = 1'b1;
        step();
        check("rstg_grant", 32'(grant), 32'd0);
        check("rstg_rw", 32'(rw), 32'd1);
        check("rstg_busen", 32'(busen), 32'd0);
        check("rstg_clock_stop", 32'(clock_stop), 32'd0);
        check("rstg_bus_drive", 32'(bus_drive), 32'd0);
        reset = 1'b0;
        req = 2'b10;
        for (int i = 0; i < 20; i++) begin
            step();
            check("reboot_m1_ignored", 32'(grant), 32'd0);
        end

        // req[0] dropped before grant: still granted, released next edge
        req = 2'b11;
        step();
        req = 2'b10;
        step(); step();
        check("early_drop_b2_grant", 32'(grant), 32'd0);
        step();
        check("early_drop_b3_grant", 32'(grant), 32'h1);
        step();
        check("early_drop_b4_grant", 32'(grant), 32'd0);
        wait_grant("post_reboot_m1", 2'b10, 24);
        req = 2'b00;
        step();
        check("final_rel_grant", 32'(grant), 32'd0);
        step(); step(); step();
        check("final_clock_stop", 32'(clock_stop), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
